// File: rtl/cipher_sched_pkg.sv
// Shared types and helpers for the cipher round-robin scheduler.
package cipher_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cipher_rr_sched_arb.sv
// Round-robin arbiter: grants the first asserted req searching upward from ptr with wrap.
// Purely combinational; gnt is one-hot or zero, idx is the encoded grant.
module rr_arbiter
    import cipher_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    always_comb begin
        logic [IW:0]   k;
        logic [IW-1:0] ki;
        logic          found;
        gnt   = '0;
        idx   = '0;
        k     = '0;
        ki    = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(NREQ)) begin
                k = k - (IW+1)'(NREQ);
            end
            ki = k[IW-1:0];
            if (en && !found && req[ki]) begin
                gnt[ki] = 1'b1;
                idx     = ki;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_rr_sched.sv
// Shares one fixed-latency byte cipher engine among NREQ requesters, one transaction at a time.
// Accept at T gives rsp_valid at T+ENG_LAT+2; response held until rsp_ready. CIPHER_SCHED_PRIO_EN: requester 0 preempts.
module cipher_rr_sched
    import cipher_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int N       = 8,
    parameter int ENG_LAT = 3
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*N-1:0]        req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [N-1:0]             rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    input  logic                     rsp_ready,
    output logic                     eng_en,
    output logic [N-1:0]             eng_din,
    input  logic [N-1:0]             eng_dout
);

    localparam int IW = id_w(NREQ);
    localparam int CW = $clog2(ENG_LAT) + 1;

    sched_state_t  state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;

    logic            arb_en;
    logic [NREQ-1:0] arb_req, arb_gnt, gnt;
    logic [IW-1:0]   arb_idx, gidx;
    logic            ptr_upd;

    // Gating with rst keeps req_ready low while reset is held.
    assign arb_en = rst && (state_q == IDLE);

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (arb_req),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

`ifdef CIPHER_SCHED_PRIO_EN
    always_comb begin
        arb_req    = req_valid;
        arb_req[0] = 1'b0;
        if (arb_en && req_valid[0]) begin
            gnt     = '0;
            gnt[0]  = 1'b1;
            gidx    = '0;
            ptr_upd = 1'b0;
        end else begin
            gnt     = arb_gnt;
            gidx    = arb_idx;
            ptr_upd = 1'b1;
        end
    end
`else
    always_comb begin
        arb_req = req_valid;
        gnt     = arb_gnt;
        gidx    = arb_idx;
        ptr_upd = 1'b1;
    end
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|gnt) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    hold_d = req_data[gidx*N +: N];
                    id_d   = gidx;
                    if (ptr_upd) begin
                        rr_ptr_d = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
                    end
                end
            end
            ISSUE: cnt_d = CW'(ENG_LAT-1);
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = eng_dout;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        req_ready = gnt;
        eng_en    = (state_q == ISSUE) || (state_q == WAIT);
        eng_din   = hold_q;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        rsp_id    = id_q;
    end

endmodule

// File: tb/tb_cipher_rr_sched.sv
// Scoreboard bench for cipher_rr_sched with a behavioural permute/XOR engine.
module tb_cipher_rr_sched;

    localparam int NREQ    = 4;
    localparam int N       = 8;
    localparam int ENG_LAT = 3;

    logic                clock;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic [N-1:0]        rsp_data;
    logic [1:0]          rsp_id;
    logic                rsp_ready;
    logic                eng_en;
    logic [N-1:0]        eng_din;
    logic [N-1:0]        eng_dout;

    cipher_rr_sched #(.NREQ(NREQ), .N(N), .ENG_LAT(ENG_LAT)) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .eng_en    (eng_en),
        .eng_din   (eng_din),
        .eng_dout  (eng_dout)
    );

    function automatic logic [7:0] engine(input logic [7:0] x);
        return {x[3:0], x[7:4]} ^ 8'h3C;
    endfunction

    assign eng_dout = engine(eng_din);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard entry: {id, ciphertext}
    logic [9:0] exp_q[$];
    int         gid_log[$];
    int         gcyc_log[$];
    int         m_ptr    = 0;
    int         acc_cyc  = 0;
    int         en_cnt   = 0;
    int         n_rsp    = 0;
    int         hs_cyc   = 0;
    logic [7:0] cur_plain = '0;
    logic       prev_rv  = 1'b0;

    function automatic int model_grant(input logic [NREQ-1:0] rv, input int ptr, output logic upd);
        int k;
        upd = 1'b1;
`ifdef CIPHER_SCHED_PRIO_EN
        if (rv[0]) begin
            upd = 1'b0;
            return 0;
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            k = (ptr + i) % NREQ;
`ifdef CIPHER_SCHED_PRIO_EN
            if (k == 0) continue;
`endif
            if (rv[k]) return k;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        if (!rst) begin
            exp_q.delete();
            m_ptr   = 0;
            prev_rv = 1'b0;
        end else begin
            if (eng_en) begin
                en_cnt++;
                check("eng_din", eng_din, cur_plain);
            end
            if (rsp_valid && !prev_rv) begin
                check("latency", cyc - acc_cyc, ENG_LAT + 2);
                check("eng_en_cycles", en_cnt, ENG_LAT + 1);
            end
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc;
                n_rsp++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e[7:0]);
                    check("rsp_id", rsp_id, e[9:8]);
                end
            end
            if (req_ready != '0) begin
                int         g;
                logic       upd;
                logic [3:0] eg;
                g  = model_grant(req_valid, m_ptr, upd);
                eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
                check("grant", req_ready, eg);
                if (g >= 0) begin
                    cur_plain = req_data[g*N +: N];
                    exp_q.push_back({2'(g), engine(cur_plain)});
                    if (upd) m_ptr = (g + 1) % NREQ;
                    gid_log.push_back(g);
                    gcyc_log.push_back(cyc);
                end
                acc_cyc = cyc;
                en_cnt  = 0;
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
        gid_log.delete();
        gcyc_log.delete();
    endtask

    task automatic wait_grants(input int n);
        int b = 0;
        while (gid_log.size() < n && b < 300) begin
            @(posedge clock);
            b++;
        end
        #1;
        check("grant_timeout", gid_log.size() >= n, 1);
    endtask

    task automatic wait_rsps(input int target);
        int b = 0;
        while (n_rsp < target && b < 300) begin
            @(posedge clock);
            b++;
        end
        #1;
        check("rsp_timeout", n_rsp >= target, 1);
    endtask

    initial begin
        int base;
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [7:0] d2;

        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_eng_en", eng_en, 0);
        check("rst_eng_din", eng_din, 0);
        @(posedge clock);
        #1 rst = 1'b1;

        // Single request from requester 0
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        rsp_ready     = 1'b1;
        wait_grants(1);
        req_valid = '0;
        wait_rsps(1);

        // All requesters continuously valid: strict rotation, one grant every ENG_LAT+3 cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = 8'($urandom);
        req_valid = 4'b1111;
        base      = n_rsp;
        wait_grants(8);
        req_valid = '0;
        for (int i = 0; i < 8; i++) check("rr_order", gid_log[i], exp_order[i]);
        for (int i = 1; i < 8; i++) check("rr_spacing", gcyc_log[i] - gcyc_log[i-1], ENG_LAT + 3);
        wait_rsps(base + 8);

        // Backpressure held in RESP
        do_reset();
        rsp_ready = 1'b0;
        d2 = 8'($urandom);
        req_data[2*N +: N] = d2;
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = 4'b1111;
        begin
            int b = 0;
            while (!rsp_valid && b < 50) begin
                @(negedge clock);
                b++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, engine(d2));
            check("bp_rsp_id", rsp_id, 2);
            check("bp_req_ready", req_ready, 0);
        end
        @(posedge clock);
        #1 rsp_ready = 1'b1;
        wait_grants(2);
        req_valid = '0;
        check("bp_next_grant_cyc", gcyc_log[1] - hs_cyc, 1);
        check("bp_next_grant_id", gid_log[1], 3);
        wait_rsps(n_rsp + 1);

        // Reset during WAIT aborts the transaction
        do_reset();
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = 4'b1111;
        @(posedge clock);
        @(posedge clock);
        #2 rst = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 0);
        check("arst_eng_en", eng_en, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_rsp_id", rsp_id, 0);
        check("arst_eng_din", eng_din, 0);
        req_valid = '0;
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 rst = 1'b1;
        gid_log.delete();
        gcyc_log.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("arst_no_rsp", rsp_valid, 0);
        end
        @(posedge clock);
        #1 req_valid = 4'b1111;
        wait_grants(1);
        req_valid = '0;
        check("arst_restart_id", gid_log[0], 0);
        wait_rsps(n_rsp + 1);

        // Pointer wrap: 3, then 0, then pointer sits at 1
        do_reset();
        req_valid = 4'b1000;
        wait_grants(1);
        req_valid = 4'b0001;
        wait_grants(2);
        req_valid = 4'b0011;
        wait_grants(3);
        req_valid = '0;
        check("wrap_g0", gid_log[0], 3);
        check("wrap_g1", gid_log[1], 0);
        check("wrap_g2", gid_log[2], 1);
        wait_rsps(n_rsp + 1);

`ifdef CIPHER_SCHED_PRIO_EN
        do_reset();
        req_valid = 4'b1111;
        wait_grants(3);
        req_valid = 4'b1110;
        wait_grants(6);
        req_valid = '0;
        for (int i = 0; i < 3; i++) check("prio_g0", gid_log[i], 0);
        for (int i = 3; i < 6; i++) check("prio_rr", gid_log[i], i - 2);
        wait_rsps(n_rsp + 1);
`endif

        repeat (10) @(posedge clock);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
